// File: rtl/run_detect_scheduler_if.sv
// ---------------------------------------------------------------------------
// run_detect_scheduler_if
//   Bundles the request/grant and result signals of run_detect_scheduler.
//
//   Handshake: a source raises req[i] with its data bit on w[i] and holds both
//   stable until gnt[i]=1. The bit is consumed on the rising edge where
//   req[i] & gnt[i] = 1. gnt is combinational from req, so a source must not
//   make req depend on gnt in the same cycle. Dropping req[i] before a grant
//   withdraws the bit. Results carry no backpressure: z_valid is a one-cycle
//   strobe and z/z_ch are held until the next result.
//
//   Signals
//     clr      : synchronous clear of all channel contexts and the pointer
//     req, w   : per-channel request and data bit (N_CH wide)
//     gnt      : one-hot grant (N_CH wide)
//     z_valid  : registered, a consumed bit's result is present
//     z        : registered, run of RUN_LEN reached on z_ch
//     z_ch     : registered, channel index of the current result
//     hit_cnt  : saturating count of z=1 results (SEQ_SCHED_HIT_CNT_EN only)
//
//   Modports: master = stream side / testbench, slave = scheduler.
//   Optional feature macro: SEQ_SCHED_HIT_CNT_EN
// ---------------------------------------------------------------------------
interface run_detect_scheduler_if #(
  parameter int N_CH = 4
`ifdef SEQ_SCHED_HIT_CNT_EN
  , parameter int HIT_W = 16
`endif
);
  localparam int CH_W = $clog2(N_CH);

  logic            clr;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] w;
  logic [N_CH-1:0] gnt;
  logic            z_valid;
  logic            z;
  logic [CH_W-1:0] z_ch;
`ifdef SEQ_SCHED_HIT_CNT_EN
  logic [HIT_W-1:0] hit_cnt;
`endif

`ifdef SEQ_SCHED_HIT_CNT_EN
  modport master (output clr, req, w, input gnt, z_valid, z, z_ch, hit_cnt);
  modport slave  (input clr, req, w, output gnt, z_valid, z, z_ch, hit_cnt);
`else
  modport master (output clr, req, w, input gnt, z_valid, z, z_ch);
  modport slave  (input clr, req, w, output gnt, z_valid, z, z_ch);
`endif
endinterface

// File: rtl/run_detect_scheduler.sv
// ---------------------------------------------------------------------------
// run_detect_scheduler
//   One run-length detection engine time-shared by N_CH serial bit streams.
//   A round-robin arbiter picks one requesting channel per cycle; that
//   channel's context (seen, last bit, run count) is updated with the consumed
//   bit and a registered result (z_valid, z, z_ch) appears one cycle later.
//   z=1 once RUN_LEN identical consecutive bits have been seen on a channel,
//   and stays 1 on every further matching bit.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : run_detect_scheduler_if.slave (clr, req, w, gnt, z_valid, z,
//            z_ch, and hit_cnt when enabled)
//
//   Optional feature macro: SEQ_SCHED_HIT_CNT_EN adds a saturating HIT_W-bit
//   counter of z=1 results on bus.hit_cnt.
// ---------------------------------------------------------------------------
module run_detect_scheduler #(
  parameter int N_CH    = 4,
  parameter int RUN_LEN = 4,
  parameter int HIT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  run_detect_scheduler_if.slave   bus
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int RUN_W = $clog2(RUN_LEN + 1);

  // Elaboration-time parameter sanity.
  if (N_CH < 2)    begin : g_bad_n_ch    $error("N_CH must be >= 2");    end
  if (RUN_LEN < 2) begin : g_bad_run_len $error("RUN_LEN must be >= 2"); end
  if (HIT_W < 1)   begin : g_bad_hit_w   $error("HIT_W must be >= 1");   end

  // Channel contexts and arbiter pointer.
  logic             r_seen [N_CH];
  logic             r_last [N_CH];
  logic [RUN_W-1:0] r_run  [N_CH];
  logic [CH_W-1:0]  r_ptr;

  // Registered result.
  logic             r_z_valid;
  logic             r_z;
  logic [CH_W-1:0]  r_z_ch;

  // Arbiter outputs.
  logic             w_found;
  logic [CH_W-1:0]  w_idx;
  logic             w_take;
  logic [N_CH-1:0]  w_gnt;
  logic [CH_W-1:0]  w_ptr_nxt;

  // Shared engine datapath.
  logic             w_bit;
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_hit;

  // k-th candidate in round-robin order starting at base, wrapping at N_CH.
  function automatic logic [CH_W-1:0] rr_cand(input logic [CH_W-1:0] base,
                                               input int k);
    int c;
    c = int'(base) + k;
    if (c >= N_CH) c = c - N_CH;
    return CH_W'(c);
  endfunction

  // Search from the highest offset down so the last hit written is the one
  // closest to r_ptr; avoids a priority chain on a found flag.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (bus.req[rr_cand(r_ptr, k)]) begin
        w_found = 1'b1;
        w_idx   = rr_cand(r_ptr, k);
      end
    end
  end

  // rst and clr both suppress the grant so no bit is consumed in that cycle.
  always_comb begin
    w_take       = w_found & ~bus.clr & ~rst;
    w_gnt        = '0;
    w_gnt[w_idx] = w_take;
  end

  always_comb begin
    w_ptr_nxt = (w_idx == CH_W'(N_CH - 1)) ? '0 : w_idx + 1'b1;
  end

  // Run update for the granted channel; saturates at RUN_LEN so it never wraps.
  always_comb begin
    w_bit = bus.w[w_idx];
    if (!r_seen[w_idx] || (w_bit != r_last[w_idx])) begin
      w_run_nxt = RUN_W'(1);
    end else if (r_run[w_idx] == RUN_W'(RUN_LEN)) begin
      w_run_nxt = r_run[w_idx];
    end else begin
      w_run_nxt = r_run[w_idx] + 1'b1;
    end
    w_hit = (w_run_nxt == RUN_W'(RUN_LEN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_seen[i] <= 1'b0;
        r_last[i] <= 1'b0;
        r_run[i]  <= '0;
      end
      r_ptr     <= '0;
      r_z_valid <= 1'b0;
      r_z       <= 1'b0;
      r_z_ch    <= '0;
    end else if (bus.clr) begin
      // clr discards contexts but leaves the last z/z_ch visible.
      for (int i = 0; i < N_CH; i++) begin
        r_seen[i] <= 1'b0;
        r_last[i] <= 1'b0;
        r_run[i]  <= '0;
      end
      r_ptr     <= '0;
      r_z_valid <= 1'b0;
    end else if (w_take) begin
      r_seen[w_idx] <= 1'b1;
      r_last[w_idx] <= w_bit;
      r_run[w_idx]  <= w_run_nxt;
      r_ptr         <= w_ptr_nxt;
      r_z_valid     <= 1'b1;
      r_z           <= w_hit;
      r_z_ch        <= w_idx;
    end else begin
      r_z_valid <= 1'b0;
    end
  end

`ifdef SEQ_SCHED_HIT_CNT_EN
  logic [HIT_W-1:0] r_hit_cnt;

  // Counts on the same edge that registers z=1, so hit_cnt tracks z_valid&z.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      r_hit_cnt <= '0;
    end else if (w_take && w_hit && (r_hit_cnt != {HIT_W{1'b1}})) begin
      r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  assign bus.hit_cnt = r_hit_cnt;
`endif

  assign bus.gnt     = w_gnt;
  assign bus.z_valid = r_z_valid;
  assign bus.z       = r_z;
  assign bus.z_ch    = r_z_ch;

endmodule
